// File: rtl/vram_arbiter_n.sv
// rtl/vram_arbiter_n.sv - slot-based VRAM access arbiter with fixed and rotating priority groups
//
// Optional feature macro: VRAM_ARB_ROUND_ROBIN_EN
//   defined   -> channels FIXED_PRI..NUM_CH-1 share the slot round-robin
//   undefined -> channels FIXED_PRI..NUM_CH-1 use strict lowest-index priority
//
// Ports:
//   CLK21M        single clock
//   RESET_N       synchronous active-low reset
//   SLOT_EN       one-cycle strobe per VRAM access slot
//   DRAW_RESERVE  slot is owned by display fetch
//   DRAW_ADDR     display fetch address
//   REQ / ACK     per-channel toggle handshake (pending while they differ)
//   CH_WE         per-channel access type (1 = write)
//   CH_ADDR       packed per-channel addresses
//   CH_WDATA      packed per-channel write data
//   CH_WR_SIZE    packed per-channel size codes (0 = 8, 1 = 16, 2 = 32 bit)
//   IRAMADR       registered VRAM address
//   PRAMDBO       registered write data
//   PRAMWE_N      registered write enable, active-low
//   PRAM_WR_SIZE  registered write size code
//   GRANT_VALID   one-cycle grant pulse
//   GRANT_ID      granted channel index
//   IDLE_SLOT     one-cycle pulse for an unused slot
module vram_arbiter_n #(
    parameter int NUM_CH    = 4,
    parameter int FIXED_PRI = 2,
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 32,
    localparam int ID_W     = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
    input  logic                     CLK21M,
    input  logic                     RESET_N,
    input  logic                     SLOT_EN,
    input  logic                     DRAW_RESERVE,
    input  logic [ADDR_W-1:0]        DRAW_ADDR,
    input  logic [NUM_CH-1:0]        REQ,
    input  logic [NUM_CH-1:0]        CH_WE,
    input  logic [NUM_CH*ADDR_W-1:0] CH_ADDR,
    input  logic [NUM_CH*DATA_W-1:0] CH_WDATA,
    input  logic [NUM_CH*2-1:0]      CH_WR_SIZE,
    output logic [NUM_CH-1:0]        ACK,
    output logic [ADDR_W-1:0]        IRAMADR,
    output logic [DATA_W-1:0]        PRAMDBO,
    output logic                     PRAMWE_N,
    output logic [1:0]               PRAM_WR_SIZE,
    output logic                     GRANT_VALID,
    output logic [ID_W-1:0]          GRANT_ID,
    output logic                     IDLE_SLOT
);

    // Largest size code the data path can carry; wider requests are clamped to it.
    localparam logic [1:0] MAX_SIZE = (DATA_W == 8)  ? 2'd0 :
                                      (DATA_W == 16) ? 2'd1 : 2'd2;

    logic [NUM_CH-1:0] pending;
    logic              found;
    logic [ID_W-1:0]   win;
    logic [1:0]        win_size;
    logic [1:0]        win_size_clamped;

    assign pending = REQ ^ ACK;

`ifdef VRAM_ARB_ROUND_ROBIN_EN
    localparam int PTR_RST = (FIXED_PRI >= NUM_CH) ? 0 : FIXED_PRI;

    logic [ID_W-1:0] ptr;

    // Rotating group is searched in two passes: from the pointer upward, then
    // from the bottom of the group, which together give a wrap-around search.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < FIXED_PRI; i++) begin
            if (!found && pending[i]) begin
                found = 1'b1;
                win   = ID_W'(i);
            end
        end
        for (int i = FIXED_PRI; i < NUM_CH; i++) begin
            if (!found && pending[i] && (ID_W'(i) >= ptr)) begin
                found = 1'b1;
                win   = ID_W'(i);
            end
        end
        for (int i = FIXED_PRI; i < NUM_CH; i++) begin
            if (!found && pending[i]) begin
                found = 1'b1;
                win   = ID_W'(i);
            end
        end
    end

    // Only rotating-group grants move the pointer; fixed-group grants leave it.
    always_ff @(posedge CLK21M) begin
        if (!RESET_N) begin
            ptr <= ID_W'(PTR_RST);
        end else if (SLOT_EN && !DRAW_RESERVE && found && (int'(win) >= FIXED_PRI)) begin
            ptr <= (int'(win) == NUM_CH - 1) ? ID_W'(PTR_RST) : win + 1'b1;
        end
    end
`else
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && pending[i]) begin
                found = 1'b1;
                win   = ID_W'(i);
            end
        end
    end
`endif

    assign win_size         = CH_WR_SIZE[int'(win)*2 +: 2];
    assign win_size_clamped = (win_size > MAX_SIZE) ? MAX_SIZE : win_size;

    always_ff @(posedge CLK21M) begin
        if (!RESET_N) begin
            IRAMADR      <= '1;
            PRAMDBO      <= '0;
            PRAMWE_N     <= 1'b1;
            PRAM_WR_SIZE <= 2'd0;
            ACK          <= '0;
            GRANT_VALID  <= 1'b0;
            GRANT_ID     <= '0;
            IDLE_SLOT    <= 1'b0;
        end else begin
            GRANT_VALID <= 1'b0;
            IDLE_SLOT   <= 1'b0;
            if (SLOT_EN) begin
                if (DRAW_RESERVE) begin
                    IRAMADR  <= DRAW_ADDR;
                    PRAMWE_N <= 1'b1;
                end else if (found) begin
                    IRAMADR      <= CH_ADDR[int'(win)*ADDR_W +: ADDR_W];
                    PRAMWE_N     <= ~CH_WE[win];
                    PRAMDBO      <= CH_WE[win] ? CH_WDATA[int'(win)*DATA_W +: DATA_W] : '0;
                    PRAM_WR_SIZE <= win_size_clamped;
                    ACK[win]     <= ~ACK[win];
                    GRANT_VALID  <= 1'b1;
                    GRANT_ID     <= win;
                end else begin
                    IDLE_SLOT <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter_n.sv
// tb/tb_vram_arbiter_n.sv - scoreboard bench for vram_arbiter_n (32-bit and 8-bit data builds)
module tb_vram_arbiter_n;

    logic         CLK21M = 1'b0;
    logic         RESET_N = 1'b0;
    logic         SLOT_EN = 1'b0;
    logic         DRAW_RESERVE = 1'b0;
    logic [18:0]  DRAW_ADDR = '0;
    logic [3:0]   REQ = '0;
    logic [3:0]   CH_WE;
    logic [75:0]  CH_ADDR;
    logic [127:0] CH_WDATA;
    logic [31:0]  CH_WDATA8;
    logic [7:0]   CH_WR_SIZE;

    logic [3:0]   ACK, ack8;
    logic [18:0]  IRAMADR, addr8;
    logic [31:0]  PRAMDBO;
    logic [7:0]   dbo8;
    logic         PRAMWE_N, we_n8;
    logic [1:0]   PRAM_WR_SIZE, size8;
    logic         GRANT_VALID, gv8;
    logic [1:0]   GRANT_ID, gid8;
    logic         IDLE_SLOT, idle8;

    vram_arbiter_n u_dut (
        .CLK21M(CLK21M), .RESET_N(RESET_N), .SLOT_EN(SLOT_EN),
        .DRAW_RESERVE(DRAW_RESERVE), .DRAW_ADDR(DRAW_ADDR), .REQ(REQ),
        .CH_WE(CH_WE), .CH_ADDR(CH_ADDR), .CH_WDATA(CH_WDATA), .CH_WR_SIZE(CH_WR_SIZE),
        .ACK(ACK), .IRAMADR(IRAMADR), .PRAMDBO(PRAMDBO), .PRAMWE_N(PRAMWE_N),
        .PRAM_WR_SIZE(PRAM_WR_SIZE), .GRANT_VALID(GRANT_VALID), .GRANT_ID(GRANT_ID),
        .IDLE_SLOT(IDLE_SLOT)
    );

    vram_arbiter_n #(.DATA_W(8)) u_dut8 (
        .CLK21M(CLK21M), .RESET_N(RESET_N), .SLOT_EN(SLOT_EN),
        .DRAW_RESERVE(DRAW_RESERVE), .DRAW_ADDR(DRAW_ADDR), .REQ(REQ),
        .CH_WE(CH_WE), .CH_ADDR(CH_ADDR), .CH_WDATA(CH_WDATA8), .CH_WR_SIZE(CH_WR_SIZE),
        .ACK(ack8), .IRAMADR(addr8), .PRAMDBO(dbo8), .PRAMWE_N(we_n8),
        .PRAM_WR_SIZE(size8), .GRANT_VALID(gv8), .GRANT_ID(gid8),
        .IDLE_SLOT(idle8)
    );

    always #5 CLK21M = ~CLK21M;

    typedef struct {
        logic        gv;
        logic [1:0]  gid;
        logic        idle;
        logic [18:0] addr;
        logic [31:0] dbo;
        logic        we_n;
        logic [1:0]  size;
        logic [3:0]  ack;
        logic [7:0]  dbo8;
        logic [1:0]  size8;
    } exp_t;

    // Hand-computed per-channel grant results for the fixed channel setup below.
    logic [18:0] g_addr  [4] = '{19'h00010, 19'h00021, 19'h00032, 19'h00043};
    logic [31:0] g_dbo   [4] = '{32'h0, 32'h22222222, 32'hA5A5A5A5, 32'h0};
    logic        g_we_n  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [1:0]  g_size  [4] = '{2'd0, 2'd1, 2'd2, 2'd2};
    logic [7:0]  g_dbo8  [4] = '{8'h00, 8'h22, 8'hA5, 8'h00};

    exp_t q[$];
    exp_t cur;
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    logic slot_d = 1'b0;

    always @(posedge CLK21M) slot_d <= SLOT_EN && RESET_N;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", n, act, req);
        end
    endtask

    always @(negedge CLK21M) begin
        if (slot_d || GRANT_VALID || IDLE_SLOT || gv8 || idle8) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual gv=%0b idle=%0b required no output", GRANT_VALID, IDLE_SLOT);
            end else begin
                e = q.pop_front();
                chk("grant_valid", GRANT_VALID, e.gv);
                if (e.gv) chk("grant_id", GRANT_ID, e.gid);
                chk("idle_slot", IDLE_SLOT, e.idle);
                chk("iramadr", IRAMADR, e.addr);
                chk("pramdbo", PRAMDBO, e.dbo);
                chk("pramwe_n", PRAMWE_N, e.we_n);
                chk("pram_wr_size", PRAM_WR_SIZE, e.size);
                chk("ack", ACK, e.ack);
                chk("dbo8", dbo8, e.dbo8);
                chk("size8", size8, e.size8);
                chk("ack8", ack8, e.ack);
            end
        end
    end

    task automatic cur_reset();
        cur.gv = 1'b0; cur.gid = 2'd0; cur.idle = 1'b0; cur.addr = 19'h7FFFF;
        cur.dbo = '0; cur.we_n = 1'b1; cur.size = 2'd0; cur.ack = '0;
        cur.dbo8 = '0; cur.size8 = 2'd0;
    endtask

    task automatic exp_grant(input int w);
        cur.gv = 1'b1; cur.gid = 2'(w); cur.idle = 1'b0;
        cur.addr = g_addr[w]; cur.dbo = g_dbo[w]; cur.we_n = g_we_n[w];
        cur.size = g_size[w]; cur.dbo8 = g_dbo8[w]; cur.size8 = 2'd0;
        cur.ack[w] = ~cur.ack[w];
        q.push_back(cur);
    endtask

    task automatic exp_idle();
        cur.gv = 1'b0; cur.idle = 1'b1;
        q.push_back(cur);
    endtask

    task automatic exp_draw(input logic [18:0] a);
        cur.gv = 1'b0; cur.idle = 1'b0; cur.addr = a; cur.we_n = 1'b1;
        q.push_back(cur);
    endtask

    // Drives one slot strobe (REQ changes made just before land in the same cycle),
    // then leaves one quiet cycle.
    task automatic slot(input logic draw, input logic [18:0] da);
        DRAW_RESERVE = draw;
        DRAW_ADDR    = da;
        SLOT_EN      = 1'b1;
        @(posedge CLK21M); #1;
        SLOT_EN      = 1'b0;
        DRAW_RESERVE = 1'b0;
        @(posedge CLK21M); #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_iramadr"}, IRAMADR, 19'h7FFFF);
        chk({tag, "_pramdbo"}, PRAMDBO, 32'h0);
        chk({tag, "_pramwe_n"}, PRAMWE_N, 1'b1);
        chk({tag, "_size"}, PRAM_WR_SIZE, 2'd0);
        chk({tag, "_ack"}, ACK, 4'h0);
        chk({tag, "_ack8"}, ack8, 4'h0);
        chk({tag, "_grant_valid"}, GRANT_VALID, 1'b0);
        chk({tag, "_grant_id"}, GRANT_ID, 2'd0);
        chk({tag, "_idle"}, IDLE_SLOT, 1'b0);
    endtask

    int rr_seq [4];

    initial begin
        CH_ADDR    = {19'h00043, 19'h00032, 19'h00021, 19'h00010};
        CH_WDATA   = {32'h44444444, 32'hA5A5A5A5, 32'h22222222, 32'h11111111};
        CH_WDATA8  = {8'h44, 8'hA5, 8'h22, 8'h11};
        CH_WE      = 4'b0110;
        CH_WR_SIZE = {2'd3, 2'd2, 2'd1, 2'd0};
`ifdef VRAM_ARB_ROUND_ROBIN_EN
        rr_seq = '{2, 3, 2, 3};
`else
        rr_seq = '{2, 2, 2, 2};
`endif
        cur_reset();

        repeat (3) @(posedge CLK21M);
        #1;
        chk_reset("reset");
        RESET_N = 1'b1;
        @(posedge CLK21M); #1;

        // Nothing pending: idle pulse, address stays at all ones.
        exp_idle();
        slot(1'b0, '0);

        // Fixed-group channel 1 beats rotating channel 3; 3 follows next slot.
        REQ[3] = ~REQ[3];
        REQ[1] = ~REQ[1];
        exp_grant(1);
        slot(1'b0, '0);
        exp_grant(3);
        slot(1'b0, '0);

        // Draw reservation wins the slot; channel 0 waits one slot.
        REQ[0] = ~REQ[0];
        exp_draw(19'h01234);
        slot(1'b1, 19'h01234);
        exp_grant(0);
        slot(1'b0, '0);

        // Double toggle cancels the request.
        REQ[2] = ~REQ[2];
        REQ[2] = ~REQ[2];
        exp_idle();
        slot(1'b0, '0);

        // Channels 2 and 3 held pending; the granted one is re-requested after each ACK.
        REQ[2] = ~REQ[2];
        REQ[3] = ~REQ[3];
        for (int k = 0; k < 4; k++) begin
            exp_grant(rr_seq[k]);
            slot(1'b0, '0);
            REQ[rr_seq[k]] = ~REQ[rr_seq[k]];
        end
        exp_grant(2);
        slot(1'b0, '0);
        exp_grant(3);
        slot(1'b0, '0);

        // Reset on the cycle after a grant clears everything.
        REQ[0] = ~REQ[0];
        exp_grant(0);
        SLOT_EN = 1'b1;
        @(posedge CLK21M); #1;
        SLOT_EN = 1'b0;
        RESET_N = 1'b0;
        REQ     = '0;
        @(posedge CLK21M); #1;
        chk_reset("reset_in_flight");
        cur_reset();
        RESET_N = 1'b1;
        @(posedge CLK21M); #1;

        // Pointer restarts at the first rotating channel after reset.
        REQ[2] = ~REQ[2];
        REQ[3] = ~REQ[3];
        exp_grant(2);
        slot(1'b0, '0);
        exp_grant(3);
        slot(1'b0, '0);
        exp_idle();
        slot(1'b0, '0);

        for (int t = 0; t < 20 && q.size() != 0; t++) @(posedge CLK21M);
        #1;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
